// File: rtl/vga_text_writer.sv
// Text-mode writer for the character buffer: turns an ASCII stream into buffer
// writes, tracks the cursor, and performs row and full-screen blanking.
module vga_text_writer #(
    parameter int         COLS  = 80,
    parameter int         ROWS  = 30,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic        clear_req,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ROW = 2'd1,
        CLR_ALL = 2'd2
    } state_t;

    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
    localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);
    localparam logic [11:0] ROW_STEP  = 12'(COLS);

    state_t      state_reg, state_next;
    logic [11:0] k_reg, k_next;
    logic [6:0]  col_reg, col_next;
    logic [4:0]  row_reg, row_next;
    // row_reg*COLS, maintained incrementally so no multiplier is needed
    logic [11:0] base_reg, base_next;
    logic        wr_en_reg, wr_en_next;
    logic [11:0] wr_addr_reg, wr_addr_next;
    logic [7:0]  wr_data_reg, wr_data_next;

    logic [4:0]  row_inc;
    logic [11:0] base_inc;
    logic [11:0] cursor_addr;

    assign row_inc     = (row_reg == LAST_ROW) ? 5'd0 : row_reg + 5'd1;
    assign base_inc    = (row_reg == LAST_ROW) ? 12'd0 : base_reg + ROW_STEP;
    assign cursor_addr = base_reg + {5'd0, col_reg};

    assign char_ready = (state_reg == IDLE) && !clear_req;
    assign busy       = (state_reg != IDLE);
    assign wr_en      = wr_en_reg;
    assign wr_addr    = wr_addr_reg;
    assign wr_data    = wr_data_reg;
    assign cursor_col = col_reg;
    assign cursor_row = row_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= CLR_ALL;
            k_reg       <= 12'd0;
            col_reg     <= 7'd0;
            row_reg     <= 5'd0;
            base_reg    <= 12'd0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= 12'd0;
            wr_data_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            k_reg       <= k_next;
            col_reg     <= col_next;
            row_reg     <= row_next;
            base_reg    <= base_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        k_next       = k_reg;
        col_next     = col_reg;
        row_next     = row_reg;
        base_next    = base_reg;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;

        case (state_reg)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLR_ALL;
                    k_next     = 12'd0;
                    col_next   = 7'd0;
                    row_next   = 5'd0;
                    base_next  = 12'd0;
                end else if (char_valid) begin
                    if (char_in >= 8'h20 && char_in <= 8'h7E) begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = cursor_addr;
                        wr_data_next = char_in;
                        if (col_reg == LAST_COL) begin
                            col_next   = 7'd0;
                            row_next   = row_inc;
                            base_next  = base_inc;
                            state_next = CLR_ROW;
                            k_next     = 12'd0;
                        end else begin
                            col_next = col_reg + 7'd1;
                        end
                    end else if (char_in == 8'h0A) begin
                        // The first blank of the new row goes out immediately,
                        // so the row clear finishes COLS cycles after the LF.
                        col_next     = 7'd0;
                        row_next     = row_inc;
                        base_next    = base_inc;
                        wr_en_next   = 1'b1;
                        wr_addr_next = base_inc;
                        wr_data_next = BLANK;
                        state_next   = CLR_ROW;
                        k_next       = 12'd1;
                    end else if (char_in == 8'h0D) begin
                        col_next = 7'd0;
                    end else if (char_in == 8'h08) begin
                        if (col_reg != 7'd0) begin
                            col_next     = col_reg - 7'd1;
                            wr_en_next   = 1'b1;
                            wr_addr_next = cursor_addr - 12'd1;
                            wr_data_next = BLANK;
                        end
                    end
                end
            end
            CLR_ROW: begin
                wr_en_next   = 1'b1;
                wr_addr_next = base_reg + k_reg;
                wr_data_next = BLANK;
                k_next       = k_reg + 12'd1;
                if (k_reg == 12'(COLS - 1)) begin
                    state_next = IDLE;
                end
            end
            CLR_ALL: begin
                wr_en_next   = 1'b1;
                wr_addr_next = k_reg;
                wr_data_next = BLANK;
                k_next       = k_reg + 12'd1;
                if (k_reg == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = CLR_ALL;
                k_next     = 12'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer: clears, printables, wrap, LF/CR/BS,
// clear request priority and reset during a row clear.
module tb_vga_text_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic        clear_req = 1'b0;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    vga_text_writer dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cursor(input string tag, input int col, input int row);
        chk({tag, "_col"}, 32'(cursor_col), 32'(col));
        chk({tag, "_row"}, 32'(cursor_row), 32'(row));
    endtask

    // Called at the negedge just before the first clear write is visible.
    task automatic check_clear_all(input string tag);
        int errs;
        errs = mismatched;
        for (int e = 0; e < 2400; e++) begin
            @(negedge clk);
            chk({tag, "_wen"},  32'(wr_en),   32'd1);
            chk({tag, "_addr"}, 32'(wr_addr), 32'(e));
            chk({tag, "_data"}, 32'(wr_data), 32'h20);
            if (e < 2399) chk({tag, "_busy"}, 32'(busy), 32'd1);
        end
        chk({tag, "_busy_end"},  32'(busy),       32'd0);
        chk({tag, "_ready_end"}, 32'(char_ready), 32'd1);
        chk_cursor({tag, "_end"}, 0, 0);
        $display("clear_all %s: 2400 writes checked, %0d new mismatches", tag, mismatched - errs);
    endtask

    // Returns at a negedge where char_ready is high.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (char_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (char_ready !== 1'b1) chk({tag, "_ready_timeout"}, 32'(char_ready), 32'd1);
    endtask

    // Offer a character at the current negedge; returns at the next negedge,
    // where the registered response to the acceptance is visible.
    task automatic send(input logic [7:0] ch);
        char_in    = ch;
        char_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        $display("send %02h: wr_en=%0d addr=%0d data=%02h cursor=(%0d,%0d)",
                 ch, wr_en, wr_addr, wr_data, cursor_col, cursor_row);
    endtask

    task automatic send_lf_and_wait(input string tag);
        send(8'h0A);
        wait_ready(tag);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_wen",   32'(wr_en),      32'd0);
        chk("rst_addr",  32'(wr_addr),    32'd0);
        chk("rst_data",  32'(wr_data),    32'd0);
        chk("rst_ready", 32'(char_ready), 32'd0);
        chk("rst_busy",  32'(busy),       32'd1);
        chk_cursor("rst", 0, 0);
        rst = 1'b0;
        check_clear_all("boot");

        @(negedge clk);
        chk("idle_wen", 32'(wr_en), 32'd0);

        send(8'h41);
        chk("A_wen",  32'(wr_en),   32'd1);
        chk("A_addr", 32'(wr_addr), 32'd0);
        chk("A_data", 32'(wr_data), 32'h41);
        chk_cursor("A", 1, 0);
        @(negedge clk);
        chk("A_single", 32'(wr_en), 32'd0);

        send(8'h0D);
        chk("cr0_wen", 32'(wr_en), 32'd0);
        chk_cursor("cr0", 0, 0);

        for (int i = 0; i < 80; i++) begin
            send(8'h78);
            chk("x_wen",  32'(wr_en),   32'd1);
            chk("x_addr", 32'(wr_addr), 32'(i));
            chk("x_data", 32'(wr_data), 32'h78);
        end
        chk_cursor("wrap", 0, 1);
        chk("wrap_ready", 32'(char_ready), 32'd0);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            chk("wrapclr_wen",  32'(wr_en),   32'd1);
            chk("wrapclr_addr", 32'(wr_addr), 32'(80 + k));
            chk("wrapclr_data", 32'(wr_data), 32'h20);
            chk("wrapclr_ready", 32'(char_ready), (k == 79) ? 32'd1 : 32'd0);
        end
        chk_cursor("wrapclr", 0, 1);

        for (int r = 0; r < 28; r++) send_lf_and_wait("lf_walk");
        chk_cursor("at29", 0, 29);
        send(8'h61); send(8'h62); send(8'h63);
        chk("r29_addr", 32'(wr_addr), 32'd2322);
        chk_cursor("r29", 3, 29);
        send(8'h0A);
        chk_cursor("lf29", 0, 0);
        for (int k = 0; k < 80; k++) begin
            if (k > 0) @(negedge clk);
            chk("lfclr_wen",  32'(wr_en),   32'd1);
            chk("lfclr_addr", 32'(wr_addr), 32'(k));
            chk("lfclr_data", 32'(wr_data), 32'h20);
            chk("lfclr_ready", 32'(char_ready), (k == 79) ? 32'd1 : 32'd0);
        end

        for (int r = 0; r < 5; r++) send_lf_and_wait("lf_to5");
        send(8'h61); send(8'h62); send(8'h63);
        chk_cursor("pre_cr", 3, 5);
        send(8'h0D);
        chk("cr_wen", 32'(wr_en), 32'd0);
        chk_cursor("cr", 0, 5);

        send(8'h07);
        chk("ctl_wen", 32'(wr_en), 32'd0);
        chk_cursor("ctl", 0, 5);

        char_in    = 8'h42;
        char_valid = 1'b1;
        clear_req  = 1'b1;
        #1;
        chk("creq_ready", 32'(char_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        clear_req  = 1'b0;
        chk("creq_wen",  32'(wr_en), 32'd0);
        chk("creq_busy", 32'(busy),  32'd1);
        chk_cursor("creq", 0, 0);
        check_clear_all("creq");

        send_lf_and_wait("lf_to1");
        send_lf_and_wait("lf_to2");
        for (int i = 0; i < 5; i++) send(8'h7A);
        chk_cursor("pre_bs", 5, 2);
        send(8'h08);
        chk("bs_wen",  32'(wr_en),   32'd1);
        chk("bs_addr", 32'(wr_addr), 32'd164);
        chk("bs_data", 32'(wr_data), 32'h20);
        chk_cursor("bs", 4, 2);
        send(8'h0D);
        send(8'h08);
        chk("bs0_wen", 32'(wr_en), 32'd0);
        chk_cursor("bs0", 0, 2);

        send(8'h0A);
        repeat (10) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_wen",  32'(wr_en), 32'd0);
        chk("rstmid_busy", 32'(busy),  32'd1);
        chk_cursor("rstmid", 0, 0);
        check_clear_all("rstmid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_text_writer.md
# vga_text_writer

Text-mode writer for the VGA character display: accepts a stream of ASCII codes over a valid/ready handshake, maintains a cursor, interprets control codes and issues write transactions into the character buffer RAM that the glyph renderer reads each frame. It sits between the keyboard/UART/song-title logic and the text buffer. It owns all buffer writes, including full-screen and per-row blanking.

## Interface
- `COLS`, 80: characters per row (640 px / 8 px glyph).
- `ROWS`, 30: rows per screen (480 px / 16 px glyph).
- `BLANK`, 8'h20: code written when clearing.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `char_in`  in  8  ASCII code offered.
- `char_valid`  in  1  `char_in` is valid.
- `char_ready`  out  1  block can accept a character this cycle.
- `clear_req`  in  1  request a full-screen clear; sampled only in IDLE.
- `wr_en`  out  1  buffer write strobe, one write per cycle.
- `wr_addr`  out  12  buffer address, row*COLS+col.
- `wr_data`  out  8  code to write.
- `cursor_col`  out  7  current column.
- `cursor_row`  out  5  current row.
- `busy`  out  1  high when state is not IDLE.

## Operation
- States: IDLE, CLR_ROW, CLR_ALL. The clear index `k` is an internal counter.
- Reset: state goes to CLR_ALL with `k`=0, and the cursor goes to (0,0). Registered outputs after the reset edge are `wr_en`=0, `wr_addr`=0 and `wr_data`=0. `char_ready`=0 and `busy`=1.
- `char_ready` = (state==IDLE) & ~`clear_req`. A character is accepted on an edge where `char_valid` & `char_ready` are both high.
- `clear_req` in IDLE has priority over `char_valid`. Any offered character is not accepted. The block moves to CLR_ALL with `k`=0 and the cursor goes to (0,0).
- CLR_ALL: each cycle writes `BLANK` to address `k`, for `k` = 0 to COLS*ROWS-1. After the last write it returns to IDLE.
- Printable characters (0x20–0x7E): write `char_in` at the cursor, then advance `cursor_col`.
  - If `cursor_col` was COLS-1, the column wraps to 0.
  - On that wrap, the row advances to (row+1) mod ROWS and the block enters CLR_ROW with `k`=0.
- 0x0A (LF): no write. The column goes to 0, the row goes to (row+1) mod ROWS, and the block enters CLR_ROW.
- 0x0D (CR): no write. The column goes to 0 and the state stays IDLE.
- 0x08 (BS):
  - If col>0: the column goes to col-1 and `BLANK` is written at the new position.
  - If col=0: no write and no cursor change.
- All other codes are consumed with no write and no cursor change.
- CLR_ROW: writes `BLANK` to row*COLS+k for `k` = 0 to COLS-1, using the new row. After the last write it returns to IDLE.
- Arithmetic: the maximum address is 2399, which fits 12 bits. The row base may be kept as an accumulator instead of a multiplier. The visible `wr_addr` must equal row*COLS+col exactly.

## Timing
- All outputs are registered except `char_ready`.
- Character write latency: `wr_en` is high in the cycle after acceptance, for exactly one cycle. The cursor outputs update on the same edge.
- Back-to-back printables without a wrap: one accepted per cycle, one write per cycle.
- After a wrap or LF accepted at edge N:
  - The character write, if any, appears in cycle N+1.
  - Clear writes appear in cycles N+1 to N+COLS for LF.
  - For a wrap, clear writes appear in cycles N+2 to N+COLS+1.
  - `char_ready` returns in the cycle of the last clear write.
- CLR_ALL takes exactly COLS*ROWS write cycles. `char_ready` rises in the cycle of the final write.
- `wr_en` is 0 in every cycle with no write.
- `rst` during any state aborts it on that edge. There is no partial write afterwards, and CLR_ALL restarts from `k`=0.
- `clear_req` and `char_valid` are ignored outside IDLE. `clear_req` is not latched.

## Test plan
- Reset, then idle: 2400 writes of 0x20 to addresses 0..2399 on consecutive cycles. `busy` falls and `char_ready` rises in the last write cycle, with the cursor at (0,0).
- Send 'A' (0x41) at (0,0): the next cycle shows `wr_en`=1, addr 0, data 0x41, and the cursor at (1,0).
- Send 80 consecutive 'x' characters:
  - The 80th writes addr 79.
  - Then 80 blank writes cover addresses 80..159.
  - The cursor ends at (0,1) and `char_ready` is low throughout the clear.
- Cursor at (3,29), send LF: blank writes to addresses 0..79 and the cursor moves to (0,0). Also: CR at (3,5) gives the cursor (0,5) with no write.
- BS at (5,2) writes 0x20 to addr 164 and moves the cursor to (4,2). BS at (0,2) produces no write.
- `clear_req` and `char_valid` with 'B' in the same IDLE cycle: 'B' is not accepted and a full clear runs. `rst` asserted midway through CLR_ROW gives `wr_en`=0 next cycle, then the full clear from addr 0.
